// File: rtl/my_seq_alu_pkg.sv
// rtl/my_seq_alu_pkg.sv - opcode constants, FSM states and helpers for my_seq_alu
package alu_pkg;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_AND  = 5'b00100;
  localparam logic [4:0] ALU_OR   = 5'b00101;
  localparam logic [4:0] ALU_XOR  = 5'b00110;
  localparam logic [4:0] ALU_NOR  = 5'b00111;
  localparam logic [4:0] ALU_SLL  = 5'b01000;
  localparam logic [4:0] ALU_SRL  = 5'b01001;
  localparam logic [4:0] ALU_SRA  = 5'b01010;
  localparam logic [4:0] ALU_SLT  = 5'b01011;
  localparam logic [4:0] ALU_SLTU = 5'b01100;
  localparam logic [4:0] ALU_MUL  = 5'b10000;
  localparam logic [4:0] ALU_DIVU = 5'b10001;
  localparam logic [4:0] ALU_REMU = 5'b10010;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  typedef enum logic [1:0] {MD_MUL, MD_DIVU, MD_REMU} md_mode_t;

  function automatic logic is_multicycle(input logic [4:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  function automatic md_mode_t md_mode_of(input logic [4:0] op);
    if (op == ALU_MUL)  return MD_MUL;
    if (op == ALU_DIVU) return MD_DIVU;
    return MD_REMU;
  endfunction

endpackage

// File: rtl/my_seq_alu_if.sv
// rtl/my_seq_alu_if.sv - operand/result handshake bundle between pipeline and my_seq_alu
interface my_seq_alu_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       alu_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, A, B, alu_op, out_ready,
    input  in_ready, out_valid, F, zero, err
  );

  modport slave (
    input  in_valid, A, B, alu_op, out_ready,
    output in_ready, out_valid, F, zero, err
  );
endinterface

// File: rtl/my_seq_alu_muldiv.sv
// rtl/my_seq_alu_muldiv.sv - one-bit-per-cycle unsigned shift-add multiply and restoring divide
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_mode_t         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  md_mode_t         mode_q;
  logic             running_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, opnd_q, lo_q;
  logic [WIDTH-1:0] acc_n, opnd_n, lo_n;
  logic [WIDTH:0]   rshift, diff;

  // acc = product / partial remainder, opnd = multiplicand / divisor, lo = multiplier / quotient
  always_comb begin
    rshift = {acc_q, lo_q[WIDTH-1]};
    diff   = rshift - {1'b0, opnd_q};
    acc_n  = acc_q;
    opnd_n = opnd_q;
    lo_n   = lo_q;
    if (mode_q == MD_MUL) begin
      acc_n  = lo_q[0] ? acc_q + opnd_q : acc_q;
      opnd_n = opnd_q << 1;
      lo_n   = lo_q >> 1;
    end else if (diff[WIDTH]) begin
      acc_n = rshift[WIDTH-1:0];
      lo_n  = {lo_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_n = diff[WIDTH-1:0];
      lo_n  = {lo_q[WIDTH-2:0], 1'b1};
    end
  end

  // Final-iteration values are presented combinationally so the caller latches them on the done edge
  assign done   = running_q && (cnt_q == CW'(WIDTH - 1));
  assign result = (mode_q == MD_DIVU) ? lo_n : acc_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MD_MUL;
      running_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      lo_q      <= '0;
    end else if (start) begin
      mode_q    <= mode;
      running_q <= 1'b1;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= (mode == MD_MUL) ? a : b;
      lo_q      <= (mode == MD_MUL) ? b : a;
    end else if (running_q) begin
      acc_q  <= acc_n;
      opnd_q <= opnd_n;
      lo_q   <= lo_n;
      cnt_q  <= cnt_q + 1'b1;
      if (done) running_q <= 1'b0;
    end
  end
endmodule

// File: rtl/my_seq_alu.sv
// rtl/my_seq_alu.sv - handshaked ALU: single-cycle datapath, control FSM and registered result
module my_seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  my_seq_alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] f_q;
  logic             zero_q, err_q, out_valid_q;
  logic [WIDTH-1:0] sc_res;
  logic             sc_err;
  logic [SW-1:0]    shamt;
  logic             md_start, md_done;
  logic [WIDTH-1:0] md_result;

  assign shamt = bus.B[SW-1:0];

  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (bus.alu_op)
      ALU_ADD:  sc_res = bus.A + bus.B;
      ALU_SUB:  sc_res = bus.A - bus.B;
      ALU_AND:  sc_res = bus.A & bus.B;
      ALU_OR:   sc_res = bus.A | bus.B;
      ALU_XOR:  sc_res = bus.A ^ bus.B;
      ALU_NOR:  sc_res = ~(bus.A | bus.B);
      ALU_SLL:  sc_res = bus.A << shamt;
      ALU_SRL:  sc_res = bus.A >> shamt;
      ALU_SRA:  sc_res = $signed(bus.A) >>> shamt;
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      ALU_MUL, ALU_DIVU, ALU_REMU: sc_res = '0;
      default:  sc_err = 1'b1;
    endcase
  end

  assign md_start = (state_q == ST_IDLE) && bus.in_valid && is_multicycle(bus.alu_op);

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .mode   (md_mode_of(bus.alu_op)),
    .a      (bus.A),
    .b      (bus.B),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      f_q         <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.in_valid) begin
          if (is_multicycle(bus.alu_op)) begin
            state_q <= ST_BUSY;
          end else begin
            f_q         <= sc_res;
            zero_q      <= (sc_res == '0);
            err_q       <= sc_err;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_BUSY: if (md_done) begin
          f_q         <= md_result;
          zero_q      <= (md_result == '0);
          err_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.F         = f_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;
endmodule
